// File: rtl/window_builder_if.sv
// Pixel stream in and 3x3 window out, shared by the window builder and the intensity stage.
// The slave modport is the window builder's view of these signals.
interface window_builder_if;
    logic         pixel_valid;
    logic [23:0]  pixel_in;
    logic         frame_start;
    logic [215:0] pixelData;
    logic         intensity_enable;
    logic         frame_done;

    modport master (
        output pixel_valid, pixel_in, frame_start,
        input  pixelData, intensity_enable, frame_done
    );

    modport slave (
        input  pixel_valid, pixel_in, frame_start,
        output pixelData, intensity_enable, frame_done
    );
endinterface

// File: rtl/window_builder.sv
// Streaming 3x3 RGB neighbourhood assembler: two line buffers feed a 3x3 shift window.
// A strobe is raised whenever the window is centred on an interior pixel.
module window_builder #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             n_rst,
    window_builder_if.slave  bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [23:0]   win_q [9];
    logic [23:0]   win_d [9];
    logic          intensity_enable_q, intensity_enable_d;
    logic          frame_done_q, frame_done_d;
    logic [23:0]   lb_a_q [IMG_WIDTH];
    logic [23:0]   lb_b_q [IMG_WIDTH];
    logic          accept;

    assign accept = bus.pixel_valid;

    // frame_start makes the pixel of this cycle position (0,0), so it can never complete a window
    always_comb begin
        cur_col            = bus.frame_start ? '0 : col_q;
        cur_row            = bus.frame_start ? '0 : row_q;
        col_d              = cur_col;
        row_d              = cur_row;
        win_d              = win_q;
        intensity_enable_d = 1'b0;
        frame_done_d       = 1'b0;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb_b_q[cur_col];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb_a_q[cur_col];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = bus.pixel_in;
            intensity_enable_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            frame_done_d       = intensity_enable_d && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q              <= '0;
            row_q              <= '0;
            win_q              <= '{default: '0};
            intensity_enable_q <= 1'b0;
            frame_done_q       <= 1'b0;
        end else begin
            col_q              <= col_d;
            row_q              <= row_d;
            win_q              <= win_d;
            intensity_enable_q <= intensity_enable_d;
            frame_done_q       <= frame_done_d;
        end
    end

    // Line buffers need no reset: every entry is rewritten before it reaches a valid window
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b_q[cur_col] <= lb_a_q[cur_col];
            lb_a_q[cur_col] <= bus.pixel_in;
        end
    end

    assign bus.pixelData        = {win_q[0], win_q[1], win_q[2],
                                   win_q[3], win_q[4], win_q[5],
                                   win_q[6], win_q[7], win_q[8]};
    assign bus.intensity_enable = intensity_enable_q;
    assign bus.frame_done       = frame_done_q;
endmodule

// File: doc/window_builder.md
# window_builder

Streaming 3x3 neighbourhood assembler that sits directly upstream of the intensity stage. It accepts one 24-bit RGB pixel per cycle in raster order and keeps two line buffers plus a 3x3 shift window. Whenever a complete 3x3 window centred on an interior pixel exists, it presents the window as a 216-bit `pixelData` bus and pulses `intensity_enable` for one cycle. The outputs connect one-to-one to the intensity stage inputs of the same names.

## Interface
- `IMG_WIDTH`, default 640: pixels per row; must be at least 3.
- `IMG_HEIGHT`, default 480: rows per frame; must be at least 3.
- `clk` input 1: system clock; all state updates on the rising edge.
- `n_rst` input 1: reset, asynchronous and active-low.
- `pixel_valid` input 1: `pixel_in` is valid this cycle and is accepted.
- `pixel_in` input 24: RGB pixel in raster order.
- `frame_start` input 1: synchronous frame restart; clears row and column counters.
- `pixelData` output 216: 3x3 window of RGB pixels.
- `intensity_enable` output 1: one-cycle strobe; `pixelData` holds a valid window.
- `frame_done` output 1: one-cycle strobe coinciding with the final window of a frame.

## Operation
- Window layout is row-major, oldest first:
  - `[215:192]` = (r-2, c-2); `[191:168]` = (r-2, c-1); `[167:144]` = (r-2, c).
  - `[143:120]` = (r-1, c-2); … ; `[23:0]` = (r, c), the pixel just accepted.
- Counters:
  - `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - `col` advances on each accepted pixel.
  - At `col` = IMG_WIDTH-1, `col` wraps to 0 and `row` increments.
  - At the last pixel of `row` IMG_HEIGHT-1, both counters wrap to 0, so the next frame needs no `frame_start`.
- Line buffers: `lb_a` holds row r-1 and `lb_b` holds row r-2, each IMG_WIDTH x 24 bits. On each accepted pixel at column c:
  - The new right window column is {`lb_b[c]`, `lb_a[c]`, `pixel_in`}.
  - Existing window columns shift left by one.
  - `lb_b[c]` <= `lb_a[c]` and `lb_a[c]` <= `pixel_in`.
- Window valid condition: the accepted pixel has `row` >= 2 and `col` >= 2. Stale columns carried across a row boundary never appear with `intensity_enable` high.
- `pixel_valid` low: counters, buffers and window hold; `intensity_enable` and `frame_done` are 0; `pixelData` holds its last value.
- `frame_start`:
  - Counters go to 0. Line-buffer contents are not cleared; they are never used before being rewritten.
  - `frame_start` together with `pixel_valid`: the pixel is accepted as (0,0) of the new frame.
  - A window that would have been valid in that cycle is suppressed.
- Line-buffer contents after reset are don't-care.

## Timing
- Reset values: `pixelData` = 0, `intensity_enable` = 0, `frame_done` = 0; counters and window registers = 0.
- Latency: pixel accepted at edge N → `pixelData`, `intensity_enable` and `frame_done` updated at edge N, visible in cycle N+1. `pixelData` is driven directly from the window registers.
- `intensity_enable` is high for exactly one cycle per valid accepted pixel. With `pixel_valid` held high it can stay high on consecutive cycles.
- Number of windows per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- `frame_done` is high only in the same cycle as the window for (IMG_HEIGHT-1, IMG_WIDTH-1).
- Throughput is one pixel per cycle with no backpressure; the downstream stage must accept every strobe.
- `n_rst` asserted mid-frame:
  - Outputs go to 0 immediately (asynchronously) and counters clear.
  - The first pixel after release is (0,0).

## Test plan
- Basic frame, IMG_WIDTH=4, IMG_HEIGHT=3, pixel k = 24'h0000k (k=0..11), `pixel_valid` continuous:
  - Exactly 2 strobes, in the cycles after k=10 and k=11.
  - First window = {0,1,2,4,5,6,8,9,10}; second window = {1,2,3,5,6,7,9,10,11}.
  - `frame_done` high only with the second window.
- Same frame with `pixel_valid` low for 3 cycles between every pixel → identical windows. `intensity_enable` and `frame_done` are 0 during gaps and `pixelData` is stable.
- Two back-to-back 4x3 frames, second frame k = 24'h10+k, no `frame_start`:
  - No strobes during second-frame rows 0–1.
  - Second-frame windows = first-frame windows + 24'h10.
- `frame_start` asserted with `pixel_valid` on k=6 of a frame → counters restart and k=6 is (0,0). Windows then appear only after 10 further pixels, with first window contents {6,7,8,10,11,12,14,15,16}.
- `n_rst` pulsed low mid-row-2 → all outputs 0 asynchronously. A following full 12-pixel frame produces exactly 2 correct windows.
- IMG_WIDTH=5, IMG_HEIGHT=4 frame, k=0..19 → 6 strobes at k=12,13,14,17,18,19. `frame_done` is high only at k=19.
